// File: rtl/line_buffer_scanout.sv
`default_nettype none
// ============================================================================
// Module      : line_buffer_scanout
// Description : Reader end of the line buffer. Fetches one line word by word
//               (word 0 first) into a 2-entry word FIFO and streams it out one
//               sub-pixel per beat over valid/ready, lowest byte first.
//               Optional feature macro CLEAR_AFTER_READ_EN: when defined,
//               every word read is zeroed through the second buffer port one
//               cycle after its read so the next line starts transparent.
// Revision    : 1.0 - initial release
// ============================================================================
module line_buffer_scanout #(
    parameter int LB_WORDS     = 128,
    parameter int ADDR_W       = 7,
    parameter int PIX_W        = 8,
    parameter int PIX_PER_WORD = 16
) (
    input  logic                          clk_draw,
    input  logic                          rst_draw_n,
    input  logic                          line_start,
    input  logic [ADDR_W:0]               line_words,
    output logic                          lb_rd_en,
    output logic [ADDR_W-1:0]             lb_rd_addr,
    input  logic [PIX_W*PIX_PER_WORD-1:0] lb_rd_data,
    output logic                          lb_clr_en,
    output logic [ADDR_W-1:0]             lb_clr_addr,
    output logic [PIX_W-1:0]              pix_data,
    output logic                          pix_valid,
    input  logic                          pix_ready,
    output logic                          pix_last,
    output logic                          busy
);

    localparam int              c_word_w    = PIX_W * PIX_PER_WORD;
    localparam int              c_idx_w     = $clog2(PIX_PER_WORD);
    localparam logic [ADDR_W:0] c_full_line = (ADDR_W + 1)'(LB_WORDS);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(PIX_PER_WORD - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    logic [ADDR_W:0]     r_line_words;   // words in this line, 1..LB_WORDS
    logic [ADDR_W:0]     r_issued;       // reads issued so far in this line
    logic [ADDR_W:0]     r_words_out;    // index of the word at the FIFO head
    logic                r_inflight;     // a read was issued last cycle
    logic [1:0]          r_count;        // words held in the FIFO
    logic                r_wr_ptr;
    logic                r_rd_ptr;
    logic [c_idx_w-1:0]  r_idx;          // byte index into the head word
    logic [c_word_w-1:0] r_fifo [2];

    logic                w_push;
    logic                w_accept;
    logic                w_word_done;
    logic                w_last_word;
    logic                w_room;
    logic [c_word_w-1:0] w_head;

    // Returning read data is captured exactly one cycle after its strobe.
    assign w_push      = r_inflight;
    assign pix_valid   = (r_count != 2'd0);
    assign w_accept    = pix_valid & pix_ready;
    assign w_word_done = w_accept & (r_idx == c_last_idx);
    assign w_last_word = (r_words_out == (r_line_words - 1'b1));
    assign pix_last    = pix_valid & (r_idx == c_last_idx) & w_last_word;
    assign busy        = (r_state == S_RUN);

    // Words held plus the read still in flight never exceed the FIFO depth.
    assign w_room      = (({1'b0, r_count} + {2'b00, r_inflight}) < 3'd2);
    assign lb_rd_en    = (r_state == S_RUN) & (r_issued < r_line_words) & w_room;
    assign lb_rd_addr  = r_issued[ADDR_W-1:0];

    // Gate the byte mux so an empty FIFO never shows stale storage.
    assign w_head      = r_fifo[r_rd_ptr];
    assign pix_data    = pix_valid ? w_head[r_idx*PIX_W +: PIX_W] : '0;

    // Line control FSM: read issue, FIFO occupancy and byte sequencing.
    always_ff @(posedge clk_draw) begin
        if (!rst_draw_n) begin
            r_state      <= S_IDLE;
            r_line_words <= '0;
            r_issued     <= '0;
            r_words_out  <= '0;
            r_inflight   <= 1'b0;
            r_count      <= 2'd0;
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_idx        <= '0;
        end else begin
            r_inflight <= lb_rd_en;
            case (r_state)
                S_IDLE: begin
                    if (line_start) begin
                        r_line_words <= (line_words == '0) ? c_full_line : line_words;
                        r_issued     <= '0;
                        r_words_out  <= '0;
                        r_idx        <= '0;
                        r_count      <= 2'd0;
                        r_wr_ptr     <= 1'b0;
                        r_rd_ptr     <= 1'b0;
                        r_state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (lb_rd_en) begin
                        r_issued <= r_issued + 1'b1;
                    end
                    if (w_push) begin
                        r_wr_ptr <= ~r_wr_ptr;
                    end
                    if (w_word_done) begin
                        r_rd_ptr    <= ~r_rd_ptr;
                        r_idx       <= '0;
                        r_words_out <= r_words_out + 1'b1;
                    end else if (w_accept) begin
                        r_idx <= r_idx + 1'b1;
                    end
                    case ({w_push, w_word_done})
                        2'b10:   r_count <= r_count + 2'd1;
                        2'b01:   r_count <= r_count - 2'd1;
                        default: r_count <= r_count;
                    endcase
                    if (pix_last && pix_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Word storage; occupancy lives in the FSM so the data needs no reset.
    always_ff @(posedge clk_draw) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= lb_rd_data;
        end
    end

`ifdef CLEAR_AFTER_READ_EN
    logic [ADDR_W-1:0] r_clr_addr;

    // Remember each read address so it can be zeroed the following cycle.
    always_ff @(posedge clk_draw) begin
        if (!rst_draw_n) begin
            r_clr_addr <= '0;
        end else if (lb_rd_en) begin
            r_clr_addr <= lb_rd_addr;
        end
    end

    assign lb_clr_en   = r_inflight;
    assign lb_clr_addr = r_clr_addr;
`else
    assign lb_clr_en   = 1'b0;
    assign lb_clr_addr = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_line_buffer_scanout.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_buffer_scanout
// Description : Self-checking bench for line_buffer_scanout. A line buffer
//               model answers reads one cycle later and applies clears; a
//               scoreboard queue holds the expected {last, byte} beats.
//               Honours CLEAR_AFTER_READ_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_buffer_scanout;

`ifdef CLEAR_AFTER_READ_EN
    localparam int EXP_CLR     = 3;
    localparam bit ZERO_RESCAN = 1'b1;
`else
    localparam int EXP_CLR     = 0;
    localparam bit ZERO_RESCAN = 1'b0;
`endif

    logic         clk_draw;
    logic         rst_draw_n;
    logic         line_start;
    logic [7:0]   line_words;
    logic         lb_rd_en;
    logic [6:0]   lb_rd_addr;
    logic [127:0] lb_rd_data;
    logic         lb_clr_en;
    logic [6:0]   lb_clr_addr;
    logic [7:0]   pix_data;
    logic         pix_valid;
    logic         pix_ready;
    logic         pix_last;
    logic         busy;

    line_buffer_scanout dut (
        .clk_draw    (clk_draw),
        .rst_draw_n  (rst_draw_n),
        .line_start  (line_start),
        .line_words  (line_words),
        .lb_rd_en    (lb_rd_en),
        .lb_rd_addr  (lb_rd_addr),
        .lb_rd_data  (lb_rd_data),
        .lb_clr_en   (lb_clr_en),
        .lb_clr_addr (lb_clr_addr),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_last    (pix_last),
        .busy        (busy)
    );

    initial clk_draw = 1'b0;
    always #5 clk_draw = ~clk_draw;

    // Line buffer model: contents written by the stimulus, clears tracked per fill generation.
    logic [127:0] mem [128];
    int           clr_gen [128];
    int           gen = 1;

    always @(posedge clk_draw) begin
        if (lb_rd_en === 1'b1)
            lb_rd_data <= (clr_gen[lb_rd_addr] == gen) ? '0 : mem[lb_rd_addr];
        else
            lb_rd_data <= {$urandom(), $urandom(), $urandom(), $urandom()};
        if (lb_clr_en === 1'b1)
            clr_gen[lb_clr_addr] <= gen;
    end

    int         checks = 0;
    int         errors = 0;
    logic [8:0] sb [$];

    int         beats, rd_count, words_done, exp_rd_addr, max_occ, clr_count;
    int         cyc, first_cyc, last_cyc, occ;
    bit         mon_en, expect_idle, prev_stall, prev_rd_en;
    logic [7:0] prev_data;
    logic [6:0] prev_rd_addr;
    logic [8:0] e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int a, input int b, input int seed);
        return 8'(a * 16 + b + seed);
    endfunction

    function automatic logic [31:0] out_vec();
        return {5'b0, pix_valid, pix_last, busy, lb_rd_en, lb_clr_en,
                pix_data, lb_rd_addr, lb_clr_addr};
    endfunction

    task automatic tick();
        @(posedge clk_draw);
        #1;
    endtask

    task automatic fill(input int n, input int seed);
        logic [127:0] w;
        gen++;
        for (int a = 0; a < n; a++) begin
            for (int b = 0; b < 16; b++) w[8*b +: 8] = pat(a, b, seed);
            mem[a] = w;
        end
    endtask

    task automatic start_line(input int words, input int seed, input bit zeros);
        int n;
        n = (words == 0) ? 128 : words;
        for (int a = 0; a < n; a++)
            for (int b = 0; b < 16; b++)
                sb.push_back({1'((a == n - 1) && (b == 15)), zeros ? 8'h00 : pat(a, b, seed)});
        beats = 0; rd_count = 0; words_done = 0; exp_rd_addr = 0; max_occ = 0; clr_count = 0;
        line_words = 8'(words);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input int exp_beats, input int exp_reads);
        int i;
        i = 0;
        while ((busy !== 1'b0 || sb.size() != 0) && i < budget) begin
            tick();
            i++;
        end
        check("done_in_budget", 32'(i < budget), 32'd1);
        tick();
        check("beat_count", beats, exp_beats);
        check("read_count", rd_count, exp_reads);
    endtask

    initial begin
        rst_draw_n = 1'b0; line_start = 1'b1; line_words = 8'd2; pix_ready = 1'b0;
        mon_en = 1'b0; expect_idle = 1'b0; prev_stall = 1'b0; prev_rd_en = 1'b0;
        cyc = 0;

        // Monitor: read order, clear timing, occupancy, stall stability and scoreboard.
        fork
            forever begin
                @(negedge clk_draw);
                cyc++;
                if (mon_en && rst_draw_n) begin
                    if (lb_rd_en) begin
                        check("rd_addr", lb_rd_addr, exp_rd_addr);
                        exp_rd_addr++;
                        rd_count++;
                    end
                    occ = rd_count - words_done;
                    if (occ > max_occ) max_occ = occ;
                    if (lb_clr_en) begin
                        check("clr_after_rd", {prev_rd_en, prev_rd_addr}, {1'b1, lb_clr_addr});
                        clr_count++;
                    end
                    if (prev_stall) check("stall_hold", {pix_valid, pix_data}, {1'b1, prev_data});
                    if (expect_idle) begin
                        check("busy_fall", busy, 1'b0);
                        expect_idle = 1'b0;
                    end
                    if (pix_valid && pix_ready) begin
                        check("beat_expected", 32'(sb.size() != 0), 32'd1);
                        if (sb.size() != 0) begin
                            e = sb.pop_front();
                            check("beat", {pix_last, pix_data}, e);
                            if (beats == 0) first_cyc = cyc;
                            if (e[8]) begin
                                last_cyc = cyc;
                                expect_idle = 1'b1;
                            end
                        end
                        beats++;
                        if (beats % 16 == 0) words_done++;
                    end
                    prev_stall = pix_valid && !pix_ready;
                end else begin
                    prev_stall = 1'b0;
                end
                prev_data    = pix_data;
                prev_rd_en   = lb_rd_en;
                prev_rd_addr = lb_rd_addr;
            end
        join_none

        // Reset held with line_start asserted
        repeat (3) begin
            tick();
            check("reset_outputs", out_vec(), 32'd0);
        end
        rst_draw_n = 1'b1; line_start = 1'b0;
        tick();
        check("idle_after_reset", {busy, lb_rd_en}, 2'b00);
        mon_en = 1'b1;

        // Basic two-word line with latency and back-to-back beats
        pix_ready = 1'b1;
        fill(2, 0);
        start_line(2, 0, 1'b0);
        @(negedge clk_draw);
        check("read_cycle", {pix_valid, lb_rd_en, busy}, 3'b011);
        @(negedge clk_draw);
        check("data_cycle_valid", pix_valid, 1'b0);
        @(negedge clk_draw);
        check("first_valid", {pix_valid, pix_data}, {1'b1, 8'h00});
        wait_idle(200, 32, 2);
        check("consecutive_beats", last_cyc - first_cyc, 31);

        // Backpressure 1,0,0,1 with an ignored line_start while busy
        fill(1, 8'h40);
        start_line(1, 8'h40, 1'b0);
        for (int i = 0; i < 400 && (busy || sb.size() != 0); i++) begin
            pix_ready  = (i % 4 == 0) || (i % 4 == 3);
            line_start = (i == 5);
            line_words = 8'd5;
            tick();
        end
        line_start = 1'b0; pix_ready = 1'b1;
        wait_idle(50, 16, 1);

        // Full line via line_words = 0
        fill(128, 7);
        start_line(0, 7, 1'b0);
        wait_idle(3000, 2048, 128);
        check("max_occupancy", 32'(max_occ <= 2), 32'd1);

        // Clear-after-read, then rescan of the same line
        fill(3, 8'h90);
        start_line(3, 8'h90, 1'b0);
        wait_idle(200, 48, 3);
        check("clears_first_scan", clr_count, EXP_CLR);
        start_line(3, 8'h90, ZERO_RESCAN);
        wait_idle(200, 48, 3);
        check("clears_second_scan", clr_count, EXP_CLR);

        // Abort with reset after five beats, then a fresh line
        fill(4, 8'h20);
        start_line(4, 8'h20, 1'b0);
        for (int i = 0; i < 100 && beats < 5; i++) tick();
        check("abort_reached", 32'(beats >= 5), 32'd1);
        rst_draw_n = 1'b0; pix_ready = 1'b0;
        tick();
        check("abort_outputs", out_vec() & 32'hFFFF_FF80, 32'd0);
        rst_draw_n = 1'b1;
        sb.delete();
        tick();
        check("abort_idle", {busy, pix_valid, lb_clr_en}, 3'b000);
        fill(2, 8'h60);
        pix_ready = 1'b1;
        start_line(2, 8'h60, 1'b0);
        wait_idle(200, 32, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
